if_id_skid_stage: RTL and testbench

//  Parametrised elastic IF/ID pipeline stage with valid/ready handshake on both sides.
//  Two entries: main register driving the outputs, plus one skid entry.

---
 rtl/if_id_skid_stage.sv | 135 +++++++++++++
 tb/tb_if_id_skid_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// Elastic IF/ID stage: a main register drives decode and one skid entry absorbs a hand-over under backpressure.
// Latency is one cycle. in_ready_o is registered, so there is no combinational out_ready_i -> in_ready_o path.
module if_id_skid_stage #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    PC_i,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic               Flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    PC_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               in_rdy_q, in_rdy_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] main_ins_q, main_ins_d, skid_ins_q, skid_ins_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               emit;
    logic [1:0]         discard;
    logic [CNT_W:0]     cnt_sum;

    assign accept = in_valid_i & in_rdy_q;
    assign emit   = (state_q != EMPTY) & out_ready_i;

    // Held entries plus the one accepted this cycle are what a flush throws away.
    assign discard = 2'(state_q == ONE) + 2'((state_q == TWO) ? 2'd2 : 2'd0) + 2'(accept);
    assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(discard);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !emit)      state_d = TWO;
                    else if (!accept && emit) state_d = EMPTY;
                end
                TWO:     if (emit) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_pc_d  = main_pc_q;
        main_ins_d = main_ins_q;
        skid_pc_d  = skid_pc_q;
        skid_ins_d = skid_ins_q;
        cnt_d      = cnt_q;
        in_rdy_d   = (state_d != TWO);
        if (Flush_i) begin
            main_pc_d  = '0;
            main_ins_d = NOP_INSTR;
            skid_pc_d  = '0;
            skid_ins_d = NOP_INSTR;
            cnt_d      = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end else begin
            unique case (state_q)
                EMPTY, ONE: begin
                    if (accept && (state_q == EMPTY || emit)) begin
                        main_pc_d  = PC_i;
                        main_ins_d = instruction_i;
                    end else if (accept) begin
                        skid_pc_d  = PC_i;
                        skid_ins_d = instruction_i;
                    end else if (emit) begin
                        main_pc_d  = '0;
                        main_ins_d = NOP_INSTR;
                    end
                end
                TWO: begin
                    if (emit) begin
                        main_pc_d  = skid_pc_q;
                        main_ins_d = skid_ins_q;
                        skid_pc_d  = '0;
                        skid_ins_d = NOP_INSTR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            in_rdy_q   <= 1'b1;
            main_pc_q  <= '0;
            main_ins_q <= NOP_INSTR;
            skid_pc_q  <= '0;
            skid_ins_q <= NOP_INSTR;
            cnt_q      <= '0;
        end else begin
            in_rdy_q   <= in_rdy_d;
            main_pc_q  <= main_pc_d;
            main_ins_q <= main_ins_d;
            skid_pc_q  <= skid_pc_d;
            skid_ins_q <= skid_ins_d;
            cnt_q      <= cnt_d;
        end
    end

    // Main register is cleared whenever it empties, so it can drive decode directly.
    always_comb begin
        out_valid_o   = (state_q != EMPTY);
        in_ready_o    = in_rdy_q;
        PC_o          = main_pc_q;
        instruction_o = main_ins_q;
        flush_cnt_o   = cnt_q;
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed stimulus, expected emits queued, negedge monitor pops and compares.
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] pc_in, ins_in, pc_out, ins_out;
    logic [15:0] cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_pc_out, s_ins_out;
    logic [1:0]  s_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_skid_stage dut (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .PC_i(pc_in), .instruction_i(ins_in), .Flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .PC_o(pc_out), .instruction_o(ins_out), .flush_cnt_o(cnt)
    );

    // Narrow-counter copy sharing all stimulus, used to observe saturation.
    if_id_skid_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .PC_i(pc_in), .instruction_i(ins_in), .Flush_i(flush), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .PC_o(s_pc_out), .instruction_o(s_ins_out), .flush_cnt_o(s_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc);
        in_valid = v;
        pc_in    = pc;
        ins_in   = 32'hA000_0000 | pc;
    endtask

    task automatic expect_emit(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = 32'hA000_0000 | pc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_pc"}, 64'(pc_out), 64'd0);
        check({tag, "_instr"}, 64'(ins_out), 64'd0);
        check({tag, "_cnt"}, 64'(cnt), 64'd0);
        check({tag, "_sat_cnt"}, 64'(s_cnt), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Monitor: every decode handshake must match the head of the expected queue;
    // idle outputs must read as PC 0 / NOP.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_emit", 64'(pc_out), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc", 64'(pc_out), 64'(e.pc));
                    check("mon_instr", 64'(ins_out), 64'(e.ins));
                end
            end else if (!out_valid) begin
                check("mon_idle_bubble", {pc_out, ins_out}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset held two cycles with input offered
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in(1'b1, 32'd4);
        tick; tick;
        @(negedge clk);
        check_reset_vals("t1");
        tick;
        rst_n = 1'b1;
        set_in(1'b0, 32'd0);
        tick;

        // T2: back-to-back streaming
        set_in(1'b1, 32'd4); expect_emit(32'd4);
        @(negedge clk); check("t2_rdy0", 64'(in_ready), 64'd1);
        tick;
        set_in(1'b1, 32'd8); expect_emit(32'd8);
        @(negedge clk);
        check("t2_latency", 64'(out_valid), 64'd1);
        check("t2_rdy1", 64'(in_ready), 64'd1);
        tick;
        set_in(1'b1, 32'd12); expect_emit(32'd12);
        @(negedge clk); check("t2_rdy2", 64'(in_ready), 64'd1);
        tick;
        set_in(1'b0, 32'd0);
        tick; tick;
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // T3: backpressure fills skid; upstream retries while stalled
        out_ready = 1'b0;
        set_in(1'b1, 32'd4); expect_emit(32'd4);
        tick;
        set_in(1'b1, 32'd8); expect_emit(32'd8);
        tick;
        set_in(1'b1, 32'd99);
        @(negedge clk);
        check("t3_rdy_low", 64'(in_ready), 64'd0);
        check("t3_pc_held", 64'(pc_out), 64'd4);
        tick;
        @(negedge clk);
        check("t3_pc_hold2", 64'(pc_out), 64'd4);
        check("t3_rdy_low2", 64'(in_ready), 64'd0);
        tick;
        set_in(1'b0, 32'd0);
        out_ready = 1'b1;
        tick;
        @(negedge clk);
        check("t3_rdy_back", 64'(in_ready), 64'd1);
        check("t3_skid_to_main", 64'(pc_out), 64'd8);
        tick; tick;
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // T4: flush from TWO with input offered (not accepted, ready is low)
        out_ready = 1'b0;
        set_in(1'b1, 32'd4); tick;
        set_in(1'b1, 32'd8); tick;
        set_in(1'b1, 32'd16);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        set_in(1'b0, 32'd0);
        @(negedge clk);
        check("t4_out_valid", 64'(out_valid), 64'd0);
        check("t4_bubble", {pc_out, ins_out}, 64'd0);
        check("t4_cnt", 64'(cnt), 64'd2);
        check("t4_sat_cnt", 64'(s_cnt), 64'd2);
        check("t4_rdy", 64'(in_ready), 64'd1);
        tick;

        // T5: flush from ONE while accepting PC 12
        set_in(1'b1, 32'd20); tick;
        set_in(1'b1, 32'd12);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        set_in(1'b0, 32'd0);
        @(negedge clk);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_cnt", 64'(cnt), 64'd4);
        check("t5_sat_cnt", 64'(s_cnt), 64'd3);
        out_ready = 1'b1;
        tick; tick; tick;
        @(negedge clk);
        check("t5_no_emit", 64'(out_valid), 64'd0);
        tick;

        // T6: saturation after five single-entry flushes, then reset from TWO
        rst_n = 1'b0; tick;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_cnt_clr", 64'(cnt), 64'd0);
        check("t6_sat_clr", 64'(s_cnt), 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            set_in(1'b1, 32'(100 + 4 * i));
            tick;
            set_in(1'b0, 32'd0);
            flush = 1'b1;
            tick;
            flush = 1'b0;
        end
        @(negedge clk);
        check("t6_cnt", 64'(cnt), 64'd5);
        check("t6_sat", 64'(s_cnt), 64'd3);
        tick;
        set_in(1'b1, 32'd4); tick;
        set_in(1'b1, 32'd8); tick;
        set_in(1'b1, 32'd12);
        @(negedge clk);
        check("t6_two_rdy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        set_in(1'b0, 32'd0);
        @(negedge clk);
        check_reset_vals("t6_midrst");
        out_ready = 1'b1;
        tick; tick;
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
